// File: rtl/rc4_pkg.sv
// rc4_pkg: shared FSM states and sizing constants for the RC4 keystream generator.
package rc4_pkg;
  typedef enum logic [2:0] {IDLE, INIT, KSA_A, KSA_B, PRGA_A, PRGA_B, PRGA_C} state_t;
  localparam int SBOX_DEPTH = 256;
  localparam int INIT_CYCLES = 256;
  localparam int KSA_CYCLES = 512;
  localparam int PRGA_CYCLES = 3;
endpackage

// File: rtl/rc4_sbox_regfile.sv
// rc4_sbox_regfile: 256x8 S-box, two async read ports, two sync write ports with port B winning collisions.
module rc4_sbox_regfile import rc4_pkg::*; (
  input  logic       clk,
  input  logic [7:0] ra_addr,
  output logic [7:0] ra_data,
  input  logic [7:0] rb_addr,
  output logic [7:0] rb_data,
  input  logic       we_a,
  input  logic [7:0] wa_addr,
  input  logic [7:0] wa_data,
  input  logic       we_b,
  input  logic [7:0] wb_addr,
  input  logic [7:0] wb_data
);
  logic [7:0] mem [SBOX_DEPTH];
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
  always_ff @(posedge clk) begin
    if (we_a) mem[wa_addr] <= wa_data;
    if (we_b) mem[wb_addr] <= wb_data;
  end
endmodule

// File: rtl/rc4_keystream.sv
// rc4_keystream: RC4 KSA + streaming PRGA with valid/ready backpressure and drop[n].
// Define RC4_XOR_EN to add an in_valid/in_ready/in_data stage that XORs input with the keystream.
module rc4_keystream import rc4_pkg::*; #(
  parameter int MAX_KEY_BYTES = 16,
  parameter int DROP_N = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [MAX_KEY_BYTES*8-1:0] key,
  input  logic [7:0]                 key_len,
  output logic                       busy,
  output logic                       err,
  output logic                       ks_valid,
  input  logic                       ks_ready,
  output logic [7:0]                 ks_data
`ifdef RC4_XOR_EN
  ,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data
`endif
);
  state_t state;
  logic [7:0] n, i, j, t, key_idx, key_len_r, key_byte;
  logic [7:0] ra_addr, ra_data, rb_data, wa_addr, wa_data, out_byte;
  logic [MAX_KEY_BYTES*8-1:0] key_r;
  logic [15:0] drop_cnt;
  logic slot_free, bad_len, load, we_a, we_b;
  assign busy = state != IDLE;
  assign slot_free = !ks_valid || ks_ready;
  assign bad_len = key_len == 8'd0 || {1'b0, key_len} > 9'(MAX_KEY_BYTES);
`ifdef RC4_XOR_EN
  assign in_ready = state == PRGA_C && drop_cnt == 16'd0 && slot_free;
  assign load = in_ready && in_valid;
  assign out_byte = in_data ^ ra_data;
`else
  assign load = state == PRGA_C && drop_cnt == 16'd0 && slot_free;
  assign out_byte = ra_data;
`endif
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < MAX_KEY_BYTES; b++)
      if (key_idx == 8'(b)) key_byte = key_r[b*8 +: 8];
  end
  // Port A reads S[i+1] in PRGA_A, S[t] in PRGA_C, else S[i]; port B always reads S[j].
  assign ra_addr = state == PRGA_A ? i + 8'd1 : state == PRGA_C ? t : i;
  assign we_a = state inside {INIT, KSA_B, PRGA_B};
  assign we_b = state inside {KSA_B, PRGA_B};
  assign wa_addr = state == INIT ? n : i;
  assign wa_data = state == INIT ? n : rb_data;
  rc4_sbox_regfile u_sbox (
    .clk(clk), .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(j), .rb_data(rb_data),
    .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
    .we_b(we_b), .wb_addr(j), .wb_data(ra_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n <= '0;
      i <= '0;
      j <= '0;
      t <= '0;
      key_idx <= '0;
      key_len_r <= '0;
      key_r <= '0;
      drop_cnt <= '0;
      err <= 1'b0;
      ks_valid <= 1'b0;
      ks_data <= '0;
    end else begin
      err <= 1'b0;
      if (ks_valid && ks_ready) ks_valid <= 1'b0;
      if (stop) begin
        state <= IDLE;
        ks_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (bad_len) err <= 1'b1;
            else begin
              key_r <= key;
              key_len_r <= key_len;
              n <= '0;
              i <= '0;
              j <= '0;
              key_idx <= '0;
              drop_cnt <= 16'(DROP_N);
              state <= INIT;
            end
          end
          INIT: begin
            n <= n + 8'd1;
            state <= n == 8'(INIT_CYCLES - 1) ? KSA_A : INIT;
          end
          KSA_A: begin
            j <= j + ra_data + key_byte;
            state <= KSA_B;
          end
          KSA_B: begin
            key_idx <= key_idx == key_len_r - 8'd1 ? 8'd0 : key_idx + 8'd1;
            i <= i + 8'd1;
            j <= i == 8'(KSA_CYCLES / 2 - 1) ? 8'd0 : j;
            state <= i == 8'(KSA_CYCLES / 2 - 1) ? PRGA_A : KSA_A;
          end
          PRGA_A: begin
            i <= i + 8'd1;
            j <= j + ra_data;
            state <= PRGA_B;
          end
          PRGA_B: begin
            t <= ra_data + rb_data;
            state <= PRGA_C;
          end
          PRGA_C: begin
            if (drop_cnt != 16'd0) begin
              drop_cnt <= drop_cnt - 16'd1;
              state <= PRGA_A;
            end else if (load) begin
              ks_data <= out_byte;
              ks_valid <= 1'b1;
              state <= PRGA_A;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rc4_keystream.sv
// tb_rc4_keystream: directed checks of two rc4_keystream instances (DROP_N=0 and DROP_N=3).
module tb_rc4_keystream;
  logic clk = 1'b0;
  logic rst, start, stop;
  logic [127:0] key;
  logic [7:0] key_len;
  logic busy0, err0, ks_valid0, ks_ready0;
  logic [7:0] ks_data0;
  logic busy1, err1, ks_valid1, ks_ready1;
  logic [7:0] ks_data1;
  int checks = 0;
  int errors = 0;
  int got0 [16];
  int got1 [16];
  logic [7:0] exp_key [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] exp_sec [8] = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
  logic [7:0] exp_wiki [6] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
  always #5 clk = ~clk;
`ifdef RC4_XOR_EN
  logic in_valid0, in_ready0, in_valid1, in_ready1;
  logic [7:0] in_data0, in_data1;
  logic [7:0] pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] exp_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  rc4_keystream dut0 (.clk(clk), .rst(rst), .start(start), .stop(stop), .key(key), .key_len(key_len),
    .busy(busy0), .err(err0), .ks_valid(ks_valid0), .ks_ready(ks_ready0), .ks_data(ks_data0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0));
  rc4_keystream #(.DROP_N(3)) dut1 (.clk(clk), .rst(rst), .start(start), .stop(stop), .key(key), .key_len(key_len),
    .busy(busy1), .err(err1), .ks_valid(ks_valid1), .ks_ready(ks_ready1), .ks_data(ks_data1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1));
`else
  rc4_keystream dut0 (.clk(clk), .rst(rst), .start(start), .stop(stop), .key(key), .key_len(key_len),
    .busy(busy0), .err(err0), .ks_valid(ks_valid0), .ks_ready(ks_ready0), .ks_data(ks_data0));
  rc4_keystream #(.DROP_N(3)) dut1 (.clk(clk), .rst(rst), .start(start), .stop(stop), .key(key), .key_len(key_len),
    .busy(busy1), .err(err1), .ks_valid(ks_valid1), .ks_ready(ks_ready1), .ks_data(ks_data1));
`endif

  task automatic start_key(input logic [127:0] k, input logic [7:0] l);
    key = k;
    key_len = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    ks_ready0 = 1'b1;
    ks_ready1 = 1'b1;
  endtask

  // Gathers cnt bytes from one instance with ready held high; cycle 1 is the cycle after the accepted start.
  task automatic collect(input int w, input int cnt, output int first);
    int k = 0;
    int c = 1;
    first = 0;
    for (int x = 0; x < 16; x++) begin
      if (w == 0) got0[x] = -1;
      else got1[x] = -1;
    end
    while (k < cnt && c < 3000) begin
      if (w == 0 ? ks_valid0 : ks_valid1) begin
        if (first == 0) first = c;
        if (w == 0) got0[k] = {24'd0, ks_data0};
        else got1[k] = {24'd0, ks_data1};
        k++;
      end
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy0 !== 1'b0 || err0 !== 1'b0 || ks_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl0 busy=%b err=%b valid=%b required 0 0 0", busy0, err0, ks_valid0);
    end
    checks++;
    if (ks_data0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_data0 got %h required 00", ks_data0);
    end
    checks++;
    if (busy1 !== 1'b0 || err1 !== 1'b0 || ks_valid1 !== 1'b0 || ks_data1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut1 busy=%b err=%b valid=%b data=%h required 0 0 0 00", busy1, err1, ks_valid1, ks_data1);
    end
  endtask

  task automatic test_key();
    int f0;
    start_key(128'h79654B, 8'd3);
    collect(0, 10, f0);
    checks++;
    if (f0 != 772) begin
      errors++;
      $display("FAIL key_first_valid got cycle %0d required 772", f0);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (got0[k] !== {24'd0, exp_key[k]}) begin
        errors++;
        $display("FAIL key_byte%0d got %0h required %h", k, got0[k], exp_key[k]);
      end
    end
    do_stop();
  endtask

  task automatic test_backpressure();
    int k = 0;
    int c = 0;
    logic hold = 1'b0;
    logic [7:0] prev = 8'h00;
    for (int x = 0; x < 16; x++) got0[x] = -1;
    start_key(128'h746572636553, 8'd6);
    while (k < 8 && c < 8000) begin
      ks_ready0 = 1'($urandom_range(0, 1));
      if (hold) begin
        checks++;
        if (ks_valid0 !== 1'b1 || ks_data0 !== prev) begin
          errors++;
          $display("FAIL bp_hold valid=%b data=%h required 1 %h", ks_valid0, ks_data0, prev);
        end
      end
      if (ks_valid0 && ks_ready0) begin
        got0[k] = {24'd0, ks_data0};
        k++;
      end
      hold = ks_valid0 && !ks_ready0;
      prev = ks_data0;
      @(posedge clk);
      #1;
      c++;
    end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (got0[m] !== {24'd0, exp_sec[m]}) begin
        errors++;
        $display("FAIL bp_byte%0d got %0h required %h", m, got0[m], exp_sec[m]);
      end
    end
    do_stop();
  endtask

  task automatic test_drop();
    int f0, f1;
    start_key(128'h696B6957, 8'd4);
    fork
      collect(0, 6, f0);
      collect(1, 3, f1);
    join
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got0[k] !== {24'd0, exp_wiki[k]}) begin
        errors++;
        $display("FAIL wiki_byte%0d got %0h required %h", k, got0[k], exp_wiki[k]);
      end
    end
    checks++;
    if (f1 != 781) begin
      errors++;
      $display("FAIL drop_first_valid got cycle %0d required 781", f1);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got1[k] !== {24'd0, exp_wiki[k+3]}) begin
        errors++;
        $display("FAIL drop_byte%0d got %0h required %h", k, got1[k], exp_wiki[k+3]);
      end
    end
    do_stop();
  endtask

  task automatic test_err();
    int f0;
    logic [7:0] bad [2] = '{8'd0, 8'd17};
    for (int b = 0; b < 2; b++) begin
      start_key(128'h79654B, bad[b]);
      checks++;
      if (err0 !== 1'b1 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse len=%0d err=%b busy=%b required 1 0", bad[b], err0, busy0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL err_clear len=%0d err=%b busy=%b required 0 0", bad[b], err0, busy0);
      end
    end
    start_key(128'h79654B, 8'd3);
    checks++;
    if (busy0 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL err_recover busy=%b err=%b required 1 0", busy0, err0);
    end
    collect(0, 3, f0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got0[k] !== {24'd0, exp_key[k]}) begin
        errors++;
        $display("FAIL err_recover_byte%0d got %0h required %h", k, got0[k], exp_key[k]);
      end
    end
    do_stop();
  endtask

  task automatic test_stop_reset();
    int f0;
    start_key(128'h79654B, 8'd3);
    repeat (400) @(posedge clk);
    #1;
    do_stop();
    checks++;
    if (busy0 !== 1'b0 || ks_valid0 !== 1'b0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL stop_ksa busy=%b valid=%b err=%b required 0 0 0", busy0, ks_valid0, err0);
    end
    start_key(128'h79654B, 8'd3);
    repeat (800) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || err0 !== 1'b0 || ks_valid0 !== 1'b0 || ks_data0 !== 8'h00) begin
      errors++;
      $display("FAIL rst_prga busy=%b err=%b valid=%b data=%h required 0 0 0 00", busy0, err0, ks_valid0, ks_data0);
    end
    start_key(128'h79654B, 8'd3);
    collect(0, 3, f0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got0[k] !== {24'd0, exp_key[k]}) begin
        errors++;
        $display("FAIL restart_byte%0d got %0h required %h", k, got0[k], exp_key[k]);
      end
    end
    do_stop();
  endtask

`ifdef RC4_XOR_EN
  task automatic test_xor();
    int k = 0;
    int p = 0;
    int c = 0;
    logic cons;
    for (int x = 0; x < 16; x++) got0[x] = -1;
    start_key(128'h79654B, 8'd3);
    while (k < 9 && c < 3000) begin
      in_data0 = p < 9 ? pt[p] : 8'h00;
      if (ks_valid0) begin
        got0[k] = {24'd0, ks_data0};
        k++;
      end
      cons = in_ready0 && in_valid0;
      @(posedge clk);
      #1;
      if (cons) p++;
      c++;
    end
    for (int m = 0; m < 9; m++) begin
      checks++;
      if (got0[m] !== {24'd0, exp_ct[m]}) begin
        errors++;
        $display("FAIL xor_byte%0d got %0h required %h", m, got0[m], exp_ct[m]);
      end
    end
    in_data0 = 8'h00;
    do_stop();
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    key = '0;
    key_len = 8'd0;
    ks_ready0 = 1'b1;
    ks_ready1 = 1'b1;
`ifdef RC4_XOR_EN
    in_valid0 = 1'b1;
    in_valid1 = 1'b1;
    in_data0 = 8'h00;
    in_data1 = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_key();
    test_backpressure();
    test_drop();
    test_err();
    test_stop_reset();
`ifdef RC4_XOR_EN
    test_xor();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rc4_keystream.md
# rc4_keystream

Parametrised RC4 keystream generator, the streaming successor of the fixed-length RC4 core. It accepts a key of 1..MAX_KEY_BYTES bytes and runs S-box initialisation and KSA. It then produces an unbounded keystream through a valid/ready handshake with backpressure, optionally discarding the first DROP_N bytes (RC4-drop[n]). It sits between key management and the cipher datapath; an optional XOR stage turns it into a complete stream-cipher engine.

## Interface
- MAX_KEY_BYTES, 16: maximum key length in bytes (1..256).
- DROP_N, 0: number of initial PRGA bytes generated but not output (0..65535).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request new key schedule; sampled only in IDLE.
- stop  in  1  abort; return to IDLE next cycle from any state.
- key  in  MAX_KEY_BYTES*8  key bytes, byte n = key[8n+7:8n]; sampled into a register on accepted start.
- key_len  in  8  key length in bytes; sampled with key.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse: start rejected because key_len==0 or key_len>MAX_KEY_BYTES.
- ks_valid  out  1  ks_data holds a keystream byte.
- ks_ready  in  1  consumer accepts ks_data when ks_valid && ks_ready.
- ks_data  out  8  keystream byte (or ciphertext when RC4_XOR_EN is defined).

## Operation
- States: IDLE, INIT, KSA_A, KSA_B, PRGA_A, PRGA_B, PRGA_C.
- IDLE: on start with valid key_len, latch key/key_len, clear n,i,j,key_idx, drop_cnt=DROP_N, go to INIT. Invalid key_len: pulse err, stay IDLE.
- INIT: write S[n]=n, one entry per cycle, n=0..255, then KSA_A with i=0.
- KSA_A: j <= j + S[i] + key_byte[key_idx] (mod 256); latch S[i].
- KSA_B: swap S[i] and S[j]; key_idx wraps to 0 after key_len-1 (counter, no modulo); i++. After i==255, go to PRGA_A with i=j=0.
- PRGA_A: i <= i+1; j <= j + S[i+1].
- PRGA_B: swap S[i] and S[j]; t <= S[i]+S[j] (pre-swap values, sum mod 256).
- PRGA_C: read S[t]. If drop_cnt!=0: decrement and discard. Otherwise load ks_data and set ks_valid. Then go to PRGA_A.
- Backpressure: PRGA_C stalls while ks_valid && !ks_ready; a handshake in the same cycle frees the slot and the load proceeds.
- ks_valid clears on handshake with no new load. ks_data is stable while ks_valid && !ks_ready.
- i==j swap: both write ports target one address with equal data; port B wins by definition.
- start while busy: ignored. stop: clears ks_valid, busy low the next cycle, S-box contents are don't-care.
- stop and start in the same IDLE cycle: stop wins, start ignored.
- Reset mid-operation: identical to power-up. The S-box array is not reset; INIT rewrites it.

## Timing
- Reset values: busy=0, err=0, ks_valid=0, ks_data=0x00; state IDLE; i,j,n,t,key_idx=0.
- Start accepted at cycle 0: INIT occupies cycles 1..256, KSA cycles 257..768. Each PRGA byte takes 3 cycles.
- First ks_valid is high at cycle 768 + 3*(DROP_N+1) + 1 with ks_ready held high.
- Sustained throughput: 1 byte per 3 cycles with ks_ready=1.
- err asserts the cycle after the rejected start.

## Configuration
- RC4_XOR_EN defined: adds ports in_valid (in, 1), in_ready (out, 1) and in_data (in, 8).
  - PRGA_C loads a byte only when in_valid is high.
  - in_ready = PRGA_C && drop_cnt==0 && slot free.
  - ks_data = in_data ^ keystream byte.
  - Dropped bytes do not consume input.
- RC4_XOR_EN undefined: the ports are absent and ks_data is raw keystream.

## Structure
- Package rc4_pkg holds:
  - state enum;
  - SBOX_DEPTH=256;
  - INIT_CYCLES=256, KSA_CYCLES=512, PRGA_CYCLES=3.
- Sub-module rc4_sbox_regfile:
  - 256x8 array;
  - two asynchronous read ports;
  - two synchronous write ports, port B priority on address collision;
  - no reset on the array.

## Test plan
- key "Key" (4B 65 79), key_len=3, DROP_N=0, ks_ready=1 -> EB 9F 77 81 B7 34 CA 72 A7 19; first valid at cycle 772.
- key "Secret" (53 65 63 72 65 74), key_len=6, ks_ready toggled randomly -> 04 D4 6B 05 3C A8 7B 59, each byte held stable until accepted, no loss or duplication.
- DROP_N=3, key "Wiki" (57 69 6B 69) -> first output 6D then 41 B7 (bytes 4..6 of stream 60 44 DB 6D 41 B7).
- key_len=0 and key_len=MAX_KEY_BYTES+1 -> err pulse, busy stays 0; a following valid start runs normally.
- stop asserted mid-KSA and rst asserted mid-PRGA -> IDLE with all outputs at reset values; restart with "Key" reproduces EB 9F 77.
- RC4_XOR_EN defined, key "Key", in_data "Plaintext" (50 6C 61 69 6E 74 65 78 74) -> BB F3 16 E8 D9 40 AF 0A D3.
